// File: rtl/bram_rr_arbiter_if.sv
// Request/response and block-RAM port bundle for bram_rr_arbiter.
// The slave modport is the arbiter view; master is the requester/RAM environment.
interface bram_rr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int RAM_WIDTH  = 32,
  parameter int ADDR_LINES = 4
);
  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ-1:0]            req_we_i;
  logic [NUM_REQ-1:0]            req_lock_i;
  logic [NUM_REQ*ADDR_LINES-1:0] req_addr_i;
  logic [NUM_REQ*RAM_WIDTH-1:0]  req_wdata_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic                          mem_en_o;
  logic                          mem_we_o;
  logic [ADDR_LINES-1:0]         mem_addr_o;
  logic [RAM_WIDTH-1:0]          mem_wdata_o;
  logic                          mem_regce_o;
  logic                          mem_rstn_o;
  logic [RAM_WIDTH-1:0]          mem_rdata_i;
  logic [NUM_REQ-1:0]            rsp_valid_o;
  logic [RAM_WIDTH-1:0]          rsp_data_o;
  logic                          busy_o;

  modport slave (
    input  req_valid_i, req_we_i, req_lock_i, req_addr_i, req_wdata_i, mem_rdata_i,
    output req_ready_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
           mem_regce_o, mem_rstn_o, rsp_valid_o, rsp_data_o, busy_o
  );

  modport master (
    output req_valid_i, req_we_i, req_lock_i, req_addr_i, req_wdata_i, mem_rdata_i,
    input  req_ready_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
           mem_regce_o, mem_rstn_o, rsp_valid_o, rsp_data_o, busy_o
  );
endinterface

// File: rtl/bram_rr_arbiter.sv
// Round-robin arbiter sharing one block-RAM port among NUM_REQ requesters, with a
// 3-stage read tracker. Define ARB_LOCK_EN to let a requester hold the grant up to LOCK_MAX times.
module bram_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int RAM_WIDTH  = 32,
  parameter int ADDR_LINES = 4,
  parameter int LOCK_MAX   = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  bram_rr_arbiter_if.slave    bus
);
  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]      r_ptr;
  logic [NUM_REQ-1:0]    w_grant;
  logic [PTR_W-1:0]      w_gidx;
  logic [PTR_W-1:0]      w_gnext;
  logic                  w_found;
  logic                  w_hs;

  logic                  r_en;
  logic                  r_we;
  logic [ADDR_LINES-1:0] r_addr;
  logic [RAM_WIDTH-1:0]  r_wdata;
  logic                  r_rstn;
  logic [2:0]            r_trk_v;
  logic [NUM_REQ-1:0]    r_trk_id [3];

  // First valid requester at or after r_ptr, wrapping.
  always_comb begin
    int idx;
    // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
    w_grant = '0;
    w_gidx  = '0;
    w_found = 1'b0;
    idx     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(r_ptr) + i) % NUM_REQ;
      if (!w_found && bus.req_valid_i[idx]) begin
        w_found      = 1'b1;
        w_grant[idx] = 1'b1;
        w_gidx       = PTR_W'(idx);
      end
    end
  end

  assign w_hs            = w_found & ~rst_i;
  assign w_gnext         = (w_gidx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gidx + 1'b1;
  assign bus.req_ready_o = rst_i ? '0 : w_grant;

`ifdef ARB_LOCK_EN
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  logic [CNT_W-1:0] r_lock_cnt;
  logic [CNT_W-1:0] w_cnt_base;

  // A run only continues if the same requester that holds the pointer wins again.
  assign w_cnt_base = (w_gidx == r_ptr) ? r_lock_cnt : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr      <= '0;
      r_lock_cnt <= '0;
    end else if (w_hs) begin
      if (bus.req_lock_i[w_gidx] && (w_cnt_base != CNT_W'(LOCK_MAX - 1))) begin
        r_ptr      <= w_gidx;
        r_lock_cnt <= w_cnt_base + 1'b1;
      end else begin
        r_ptr      <= w_gnext;
        r_lock_cnt <= '0;
      end
    end else begin
      r_lock_cnt <= '0;
    end
  end
`else
  logic w_unused_lock;
  assign w_unused_lock = (^bus.req_lock_i) ^ (LOCK_MAX > 0);

  always_ff @(posedge clk_i) begin
    if (rst_i)     r_ptr <= '0;
    else if (w_hs) r_ptr <= w_gnext;
  end
`endif

  // Command stage: one-cycle enable; address/data hold when idle.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    r_rstn <= ~rst_i;
    if (rst_i) begin
      r_en    <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_trk_v <= '0;
    end else begin
      r_en    <= w_hs;
      r_trk_v <= {r_trk_v[1:0], w_hs & ~bus.req_we_i[w_gidx]};
      if (w_hs) begin
        r_we    <= bus.req_we_i[w_gidx];
        r_addr  <= bus.req_addr_i[int'(w_gidx)*ADDR_LINES +: ADDR_LINES];
        r_wdata <= bus.req_wdata_i[int'(w_gidx)*RAM_WIDTH +: RAM_WIDTH];
      end
    end
  end

  // NOTE: tracker IDs carry no reset; they are only observed when the matching valid bit is set.
  always_ff @(posedge clk_i) begin
    r_trk_id[0] <= w_grant;
    r_trk_id[1] <= r_trk_id[0];
    r_trk_id[2] <= r_trk_id[1];
  end

  assign bus.mem_en_o    = r_en;
  assign bus.mem_we_o    = r_we;
  assign bus.mem_addr_o  = r_addr;
  assign bus.mem_wdata_o = r_wdata;
  assign bus.mem_rstn_o  = r_rstn;
  assign bus.mem_regce_o = r_trk_v[1];
  assign bus.rsp_valid_o = r_trk_v[2] ? r_trk_id[2] : '0;
  assign bus.rsp_data_o  = bus.mem_rdata_i;
  assign bus.busy_o      = |r_trk_v;
endmodule

// File: tb/tb_bram_rr_arbiter.sv
// Scoreboard bench for bram_rr_arbiter with a two-stage block-RAM model.
// Lock expectations follow ARB_LOCK_EN when the bench is built with it.
module tb_bram_rr_arbiter;
  localparam int NR = 4;
  localparam int DW = 32;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   mon_en = 1'b0;

  typedef struct {
    logic [NR-1:0] id;
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t exp_q[$];

  bram_rr_arbiter_if #(.NUM_REQ(NR), .RAM_WIDTH(DW), .ADDR_LINES(AW)) bus ();

  bram_rr_arbiter #(.NUM_REQ(NR), .RAM_WIDTH(DW), .ADDR_LINES(AW), .LOCK_MAX(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Block-RAM model: array read/write on enable, output register on regce.
  logic [DW-1:0] ram [16];
  logic [DW-1:0] ram_lat;
  logic [DW-1:0] ram_oreg;
  initial for (int i = 0; i < 16; i++) ram[i] = '0;
  always @(posedge clk) begin
    if (bus.mem_en_o) begin
      if (bus.mem_we_o) ram[bus.mem_addr_o] <= bus.mem_wdata_o;
      else              ram_lat <= ram[bus.mem_addr_o];
    end
    if (!bus.mem_rstn_o)      ram_oreg <= '0;
    else if (bus.mem_regce_o) ram_oreg <= ram_lat;
  end
  assign bus.mem_rdata_i = ram_oreg;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: every nonzero rsp_valid_o must match the head of the queue.
  always @(negedge clk) begin
    if (mon_en && bus.rsp_valid_o !== '0) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'(bus.rsp_valid_o), 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_id", 64'(bus.rsp_valid_o), 64'(e.id));
        check("rsp_data", 64'(bus.rsp_data_o), 64'(e.data));
        check("rsp_cycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all;
    bus.req_valid_i = '0;
    bus.req_we_i    = '0;
    bus.req_lock_i  = '0;
  endtask

  task automatic set_req(input int r, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input bit lk);
    bus.req_valid_i[r]           = 1'b1;
    bus.req_we_i[r]              = we;
    bus.req_lock_i[r]            = lk;
    bus.req_addr_i[r*AW +: AW]   = a;
    bus.req_wdata_i[r*DW +: DW]  = d;
  endtask

  // One access by requester r alone; handshake expected in the current cycle.
  task automatic access(input int r, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW-1:0] exp_d, input bit push);
    logic [NR-1:0] oh;
    exp_t e;
    oh = NR'(1) << r;
    set_req(r, we, a, d, 1'b0);
    @(negedge clk);
    check("grant", 64'(bus.req_ready_o), 64'(oh));
    if (!we && push) begin
      e.id = oh; e.data = exp_d; e.due = cyc + 3;
      exp_q.push_back(e);
    end
    step;
    bus.req_valid_i[r] = 1'b0;
  endtask

  logic [NR-1:0] lock_exp [6];

  initial begin
`ifdef ARB_LOCK_EN
    lock_exp = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b0100};
`else
    lock_exp = '{4'b0100, 4'b1000, 4'b0100, 4'b1000, 4'b0100, 4'b1000};
`endif
    bus.req_addr_i  = '0;
    bus.req_wdata_i = '0;
    idle_all();
    bus.req_valid_i[0] = 1'b1;

    // Reset: outputs quiet and ready gated even with a request pending.
    repeat (3) begin
      step;
      @(negedge clk);
      check("rst_ready", 64'(bus.req_ready_o), 64'd0);
      check("rst_en", 64'(bus.mem_en_o), 64'd0);
      check("rst_addr", 64'(bus.mem_addr_o), 64'd0);
      check("rst_regce", 64'(bus.mem_regce_o), 64'd0);
      check("rst_rsp", 64'(bus.rsp_valid_o), 64'd0);
      check("rst_busy", 64'(bus.busy_o), 64'd0);
      check("rst_rstn", 64'(bus.mem_rstn_o), 64'd0);
    end
    step;
    rst = 1'b0;
    idle_all();
    mon_en = 1'b1;
    @(negedge clk);
    check("rstn_first", 64'(bus.mem_rstn_o), 64'd0);
    check("idle_en", 64'(bus.mem_en_o), 64'd0);
    step;
    @(negedge clk);
    check("rstn_high", 64'(bus.mem_rstn_o), 64'd1);
    repeat (2) begin
      step;
      @(negedge clk);
      check("idle_en", 64'(bus.mem_en_o), 64'd0);
    end
    step;

    // Fairness: all four hold valid (writes to 8..11), grants rotate from 0.
    for (int r = 0; r < NR; r++) set_req(r, 1'b1, AW'(8 + r), DW'(32'h100 + r), 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("fair_grant", 64'(bus.req_ready_o), 64'(NR'(1) << (k % NR)));
      if (k > 0) begin
        check("fair_en", 64'(bus.mem_en_o), 64'd1);
        check("fair_addr", 64'(bus.mem_addr_o), 64'(8 + ((k - 1) % NR)));
      end
      step;
    end
    idle_all();
    @(negedge clk);
    check("fair_last_en", 64'(bus.mem_en_o), 64'd1);
    check("fair_last_addr", 64'(bus.mem_addr_o), 64'd11);
    step;
    @(negedge clk);
    check("fair_idle_en", 64'(bus.mem_en_o), 64'd0);
    step;

    // Single read by req1 of a location written by req0.
    access(0, 1'b1, 4'h5, 32'hDEADBEEF, '0, 1'b0);
    @(negedge clk);
    check("wr_en", 64'(bus.mem_en_o), 64'd1);
    check("wr_we", 64'(bus.mem_we_o), 64'd1);
    check("wr_addr", 64'(bus.mem_addr_o), 64'h5);
    check("wr_data", 64'(bus.mem_wdata_o), 64'hDEADBEEF);
    step;
    access(1, 1'b0, 4'h5, '0, 32'hDEADBEEF, 1'b1);
    @(negedge clk);
    check("rd_en", 64'(bus.mem_en_o), 64'd1);
    check("rd_we", 64'(bus.mem_we_o), 64'd0);
    check("rd_regce_t1", 64'(bus.mem_regce_o), 64'd0);
    check("rd_busy", 64'(bus.busy_o), 64'd1);
    step;
    @(negedge clk);
    check("rd_regce_t2", 64'(bus.mem_regce_o), 64'd1);
    repeat (3) step;

    // Pipelined reads: fill 0..3 with 10..13, then read back one per cycle.
    for (int i = 0; i < 4; i++) access(0, 1'b1, AW'(i), DW'(10 + i), '0, 1'b0);
    for (int i = 0; i < 4; i++) access(0, 1'b0, AW'(i), '0, DW'(10 + i), 1'b1);
    repeat (5) step;

    // Write then read the same address on consecutive handshakes.
    access(2, 1'b1, 4'h7, 32'hA5A5A5A5, '0, 1'b0);
    access(3, 1'b0, 4'h7, '0, 32'hA5A5A5A5, 1'b1);
    repeat (5) step;

    // Lock: req2 asks to keep the grant while req3 also requests.
    set_req(2, 1'b1, 4'hC, 32'h22, 1'b1);
    set_req(3, 1'b1, 4'hD, 32'h33, 1'b0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("lock_grant", 64'(bus.req_ready_o), 64'(lock_exp[k]));
      step;
    end
    idle_all();
    repeat (2) step;

    // Reset mid-flight: two reads in flight are discarded.
    access(0, 1'b0, 4'h0, '0, '0, 1'b0);
    access(0, 1'b0, 4'h1, '0, '0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy_pre", 64'(bus.busy_o), 64'd1);
    step;
    @(negedge clk);
    check("midrst_busy", 64'(bus.busy_o), 64'd0);
    check("midrst_rsp", 64'(bus.rsp_valid_o), 64'd0);
    step;
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("postrst_busy", 64'(bus.busy_o), 64'd0);
      step;
    end

    check("rsp_drain", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/bram_rr_arbiter.md
# bram_rr_arbiter

Round-robin arbiter that shares one port of the team's dual-port block RAM among `NUM_REQ` requesters. It accepts one access per cycle through per-requester valid/ready handshakes and drives the RAM's enable, write-enable, address, data, output-register-enable and output-reset pins. It tracks in-flight reads through the RAM's two-stage read pipeline and returns read data tagged with a one-hot requester ID. It sits between the NLA compute units (LUT and coefficient fetchers) and the shared coefficient memory.

## Interface
- `NUM_REQ`, 4 — number of requesters (2..8).
- `RAM_WIDTH`, 32 — data width.
- `ADDR_LINES`, 4 — address width.
- `LOCK_MAX`, 4 — max consecutive locked grants (used only with `ARB_LOCK_EN`).

Ports:
- `clk_i` in 1 — clock, single domain.
- `rst_i` in 1 — reset, synchronous, active-high.
- `req_valid_i` in NUM_REQ — request valid per requester.
- `req_we_i` in NUM_REQ — 1 = write, 0 = read.
- `req_lock_i` in NUM_REQ — requester asks to keep the grant.
- `req_addr_i` in NUM_REQ*ADDR_LINES — packed addresses; requester i at slice [i*ADDR_LINES +: ADDR_LINES].
- `req_wdata_i` in NUM_REQ*RAM_WIDTH — packed write data.
- `req_ready_o` out NUM_REQ — one-hot grant, combinational.
- `mem_en_o`, `mem_we_o` out 1 — RAM port enable and write enable.
- `mem_addr_o` out ADDR_LINES — RAM address.
- `mem_wdata_o` out RAM_WIDTH — RAM write data.
- `mem_regce_o` out 1 — RAM output-register enable.
- `mem_rstn_o` out 1 — RAM output-register reset, active-low.
- `mem_rdata_i` in RAM_WIDTH — RAM registered read data.
- `rsp_valid_o` out NUM_REQ — one-hot read-response valid.
- `rsp_data_o` out RAM_WIDTH — read data, equal to `mem_rdata_i`.
- `busy_o` out 1 — any read in flight.

## Operation
- Grant:
  - Scan `req_valid_i` starting at priority pointer `ptr`, wrapping modulo NUM_REQ.
  - The first asserted bit gets `req_ready_o`; at most one bit is high.
  - A transfer (handshake) occurs when valid and ready are both high.
- Pointer update: after a handshake by requester g, `ptr <= (g+1) mod NUM_REQ`. With no handshake, `ptr` holds.
- Requester obligation: hold valid, we, addr and wdata stable until ready. A requester may drop valid without a handshake.
- Command stage:
  - On a handshake, register `mem_en_o=1`, `mem_we_o`, `mem_addr_o` and `mem_wdata_o` for exactly one cycle.
  - Otherwise `mem_en_o=0`; addr and data hold their last values.
- Read tracking:
  - 3-stage shift register of {valid, one-hot id}; only reads enter it.
  - `mem_regce_o` is high in the cycle after a read command.
  - Stage 3 drives `rsp_valid_o`.
- Writes produce no response.
- `busy_o` = OR of the tracker valid bits.
- Back-to-back reads from any mix of requesters are fully pipelined, sustaining one per cycle.

## Timing
- Handshake in cycle T:
  - `mem_en_o` high in T+1.
  - RAM array read at the end of T+1; `mem_regce_o` high in T+2.
  - `mem_rdata_i` and `rsp_valid_o` valid in T+3.
- Read latency is 3 cycles; write commit occurs at the end of T+1.
- Reset values:
  - `ptr=0`; `mem_en_o=0`, `mem_we_o=0`, `mem_addr_o=0`, `mem_wdata_o=0`.
  - `mem_regce_o=0`; `rsp_valid_o=0`; `busy_o=0`.
  - `req_ready_o=0` while `rst_i` is high.
  - `mem_rstn_o=0` while `rst_i` is high; it is registered `~rst_i`, so it goes high one cycle after reset releases.
- Reset mid-operation: all tracker entries are discarded, and no `rsp_valid_o` fires for reads issued before reset.
- Same address written then read in consecutive handshakes: the read returns the new data, since the port is serial and the write commits first.
- All requesters idle: no command is issued and `ptr` is unchanged.

## Configuration
- `ARB_LOCK_EN` defined:
  - If granted requester g handshakes with `req_lock_i[g]=1`, `ptr` stays at g and a lock counter increments.
  - When the counter reaches LOCK_MAX, `ptr` advances to g+1 and the counter clears, forcing rotation.
  - The counter also clears on any handshake without lock, or on a cycle where g has no valid.
- `ARB_LOCK_EN` undefined: `req_lock_i` is ignored and the counter is not built.

## Test plan
- Reset and idle:
  - Assert `rst_i` for 3 cycles, then release -> all outputs 0 during reset.
  - `mem_rstn_o` rises 1 cycle after release; no `mem_en_o` while idle.
- Single read: req1 reads addr 0x5 after a prior write of 0xDEADBEEF there -> `rsp_valid_o=4'b0010` and `rsp_data_o=0xDEADBEEF` exactly 3 cycles after the handshake.
- Fairness: all 4 requesters hold valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3 with one `mem_en_o` per cycle.
- Pipelined reads: req0 reads 0x0..0x3 back-to-back (contents 10..13) -> `rsp_valid_o=4'b0001` on 4 consecutive cycles with data 10,11,12,13.
- Reset mid-flight: issue 2 reads, then assert `rst_i` 1 cycle later -> no `rsp_valid_o` afterwards and `busy_o=0`.
- Lock (`ARB_LOCK_EN`, `LOCK_MAX=4`): req2 valid+lock and req3 valid -> req2 granted 4 consecutive cycles, then req3. Without the macro, grants alternate 2,3,2,3.
